// File: rtl/io_responder.sv
// IO page target for the core's single-cycle IO bus: LED register plus a
// FIFO-buffered UART transmitter that drains itself onto uart_txd.
module io_responder #(
    parameter int CLK_FREQ_HZ = 60000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16,
    parameter int LED_WIDTH   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          IO_mem_addr,
    input  logic [31:0]          IO_mem_wdata,
    input  logic                 IO_mem_wr,
    output logic [31:0]          IO_mem_rdata,
    output logic [LED_WIDTH-1:0] LEDS,
    output logic                 uart_txd
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    localparam int DIV_W        = $clog2(CLKS_PER_BIT);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_e;

    logic [2:0]           sel;
    logic                 wrLeds, wrTx, wrStat;
    logic                 fifoFull, fifoEmpty, push, pop, bitEnd, busy;
    logic [31:0]          statWord;

    logic [LED_WIDTH-1:0] ledsQ, ledsD;
    logic [CNT_W-1:0]     countQ, countD;
    logic [PTR_W-1:0]     headQ, headD, tailQ, tailD;
    logic                 overflowQ, overflowD;
    txState_e             stateQ, stateD;
    logic [DIV_W-1:0]     divQ, divD;
    logic [2:0]           bitCntQ, bitCntD;
    logic [7:0]           shiftQ, shiftD;
    logic                 txdQ, txdD;
    logic [7:0]           mem [FIFO_DEPTH];
    logic                 unusedBits;

    assign sel       = IO_mem_addr[22] ? IO_mem_addr[4:2] : 3'b000;
    assign wrLeds    = IO_mem_wr & sel[0];
    assign wrTx      = IO_mem_wr & sel[1];
    assign wrStat    = IO_mem_wr & sel[2];
    assign fifoFull  = (countQ == CNT_FULL);
    assign fifoEmpty = (countQ == '0);
    assign push      = wrTx & ~fifoFull;
    assign bitEnd    = (divQ == DIV_LAST);
    assign busy      = (stateQ != IDLE) | ~fifoEmpty;
    assign statWord  = {16'b0, 8'(countQ), 5'b0, overflowQ, fifoFull, busy};

    assign LEDS       = ledsQ;
    assign uart_txd   = txdQ;
    assign unusedBits = ^{IO_mem_addr, IO_mem_wdata};

    // Multiple select bits OR their registers together; TXDAT reads as zero.
    always_comb begin
        IO_mem_rdata = '0;
        if (sel[0]) IO_mem_rdata = IO_mem_rdata | 32'(ledsQ);
        if (sel[2]) IO_mem_rdata = IO_mem_rdata | statWord;
    end

    always_comb begin
        ledsD     = wrLeds ? IO_mem_wdata[LED_WIDTH-1:0] : ledsQ;
        headD     = pop  ? headQ + PTR_W'(1) : headQ;
        tailD     = push ? tailQ + PTR_W'(1) : tailQ;
        countD    = countQ;
        overflowD = overflowQ;
        case ({push, pop})
            2'b10:   countD = countQ + CNT_W'(1);
            2'b01:   countD = countQ - CNT_W'(1);
            default: countD = countQ;
        endcase
        if (wrStat) overflowD = 1'b0;
        // A dropped byte sets overflow even if a clear arrives in the same store.
        if (wrTx && fifoFull) overflowD = 1'b1;
    end

    always_comb begin
        stateD  = stateQ;
        divD    = divQ;
        bitCntD = bitCntQ;
        shiftD  = shiftQ;
        txdD    = txdQ;
        pop     = 1'b0;
        case (stateQ)
            IDLE: begin
                divD = '0;
                if (!fifoEmpty) begin
                    pop    = 1'b1;
                    shiftD = mem[headQ];
                    txdD   = 1'b0;
                    stateD = START;
                end
            end
            START: begin
                if (bitEnd) begin
                    divD    = '0;
                    bitCntD = 3'd0;
                    txdD    = shiftQ[0];
                    shiftD  = shiftQ >> 1;
                    stateD  = DATA;
                end else begin
                    divD = divQ + DIV_W'(1);
                end
            end
            DATA: begin
                if (bitEnd) begin
                    divD = '0;
                    if (bitCntQ == 3'd7) begin
                        txdD   = 1'b1;
                        stateD = STOP;
                    end else begin
                        bitCntD = bitCntQ + 3'd1;
                        txdD    = shiftQ[0];
                        shiftD  = shiftQ >> 1;
                    end
                end else begin
                    divD = divQ + DIV_W'(1);
                end
            end
            STOP: begin
                if (bitEnd) begin
                    divD = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!fifoEmpty) begin
                        pop    = 1'b1;
                        shiftD = mem[headQ];
                        txdD   = 1'b0;
                        stateD = START;
                    end else begin
                        stateD = IDLE;
                    end
                end else begin
                    divD = divQ + DIV_W'(1);
                end
            end
            default: begin
                stateD = IDLE;
                txdD   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[tailQ] <= IO_mem_wdata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ledsQ     <= '0;
            countQ    <= '0;
            headQ     <= '0;
            tailQ     <= '0;
            overflowQ <= 1'b0;
            stateQ    <= IDLE;
            divQ      <= '0;
            bitCntQ   <= '0;
            shiftQ    <= '0;
            txdQ      <= 1'b1;
        end else begin
            ledsQ     <= ledsD;
            countQ    <= countD;
            headQ     <= headD;
            tailQ     <= tailD;
            overflowQ <= overflowD;
            stateQ    <= stateD;
            divQ      <= divD;
            bitCntQ   <= bitCntD;
            shiftQ    <= shiftD;
            txdQ      <= txdD;
        end
    end

endmodule
